// File: rtl/door_countdown.sv
// Door/pickup countdown: samples the divided 1 Hz tick and counts whole seconds down as two BCD digits.
// Optional warning blink is compiled in with `define WARN_BLINK_EN (threshold parameter WARN_SEC).
module door_countdown (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic [6:0] load_sec,
  input  logic       hold,
  input  logic       cancel,
  input  logic       ack,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       alarm,
  output logic       warn
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_ALARM} state_t;

  state_t     r_state, w_state_n;
  logic       r_s1, r_s2, r_s3;
  logic       w_tick_rise;
  logic [3:0] r_tens, r_ones, w_tens_n, w_ones_n;
  logic [7:0] w_load_bcd;
  logic       w_load_nz;
  logic       r_running, r_expired, r_alarm, w_expired_n;

  // Saturate to 99, then split into {tens, ones}; ones fits in 4 bits so the subtraction is done mod 16.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [6:0] v;
    logic [3:0] t;
    v = (bin > 7'd99) ? 7'd99 : bin;
    t = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (int'(v) >= k * 10) t = 4'(k);
    end
    return {t, v[3:0] - (t * 4'd10)};
  endfunction

  assign w_load_bcd  = to_bcd(load_sec);
  assign w_load_nz   = |load_sec;
  assign w_tick_rise = r_s2 & ~r_s3;

  always_comb begin
    w_state_n   = r_state;
    w_tens_n    = r_tens;
    w_ones_n    = r_ones;
    w_expired_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cancel && start && w_load_nz) begin
          w_tens_n  = w_load_bcd[7:4];
          w_ones_n  = w_load_bcd[3:0];
          w_state_n = S_RUN;
        end
      end
      S_RUN, S_HOLD: begin
        if (cancel) begin
          w_tens_n  = 4'd0;
          w_ones_n  = 4'd0;
          w_state_n = S_IDLE;
        end else if (start) begin
          w_tens_n  = w_load_nz ? w_load_bcd[7:4] : 4'd0;
          w_ones_n  = w_load_nz ? w_load_bcd[3:0] : 4'd0;
          w_state_n = w_load_nz ? S_RUN : S_IDLE;
        end else if (r_state == S_HOLD) begin
          if (!hold) w_state_n = S_RUN;
        end else if (hold) begin
          w_state_n = S_HOLD;
        end else if (w_tick_rise) begin
          if (r_tens == 4'd0 && r_ones == 4'd1) begin
            w_ones_n    = 4'd0;
            w_expired_n = 1'b1;
            w_state_n   = S_ALARM;
          end else if (r_ones == 4'd0) begin
            w_ones_n = 4'd9;
            w_tens_n = r_tens - 4'd1;
          end else begin
            w_ones_n = r_ones - 4'd1;
          end
        end
      end
      S_ALARM: begin
        if (cancel) begin
          w_state_n = S_IDLE;
        end else if (start && w_load_nz) begin
          w_tens_n  = w_load_bcd[7:4];
          w_ones_n  = w_load_bcd[3:0];
          w_state_n = S_RUN;
        end else if (ack) begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // running/alarm decode the next state so they switch on the same edge as the FSM
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_s1      <= tick_in;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_tens    <= w_tens_n;
      r_ones    <= w_ones_n;
      r_running <= (w_state_n == S_RUN) || (w_state_n == S_HOLD);
      r_expired <= w_expired_n;
      r_alarm   <= (w_state_n == S_ALARM);
    end
  end

  assign sec_tens = r_tens;
  assign sec_ones = r_ones;
  assign running  = r_running;
  assign expired  = r_expired;
  assign alarm    = r_alarm;

`ifdef WARN_BLINK_EN
  parameter logic [6:0] WARN_SEC = 7'd5;

  logic       r_warn, w_warn_n;
  logic       w_load_evt, w_tick_seen;
  logic [6:0] w_rem_n;

  // Ticks discarded by hold still toggle the blink, so count any tick in RUN/HOLD not overridden by cancel/start.
  assign w_load_evt  = !cancel && start && w_load_nz;
  assign w_tick_seen = w_tick_rise && !cancel && !start &&
                       ((r_state == S_RUN) || (r_state == S_HOLD));
  assign w_rem_n     = ({3'b000, w_tens_n} * 7'd10) + {3'b000, w_ones_n};

  always_comb begin
    w_warn_n = 1'b0;
    if (((w_state_n == S_RUN) || (w_state_n == S_HOLD)) && (w_rem_n <= WARN_SEC)) begin
      if (w_load_evt)       w_warn_n = 1'b1;
      else if (w_tick_seen) w_warn_n = ~r_warn;
      else                  w_warn_n = r_warn;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) r_warn <= 1'b0;
    else      r_warn <= w_warn_n;
  end

  assign warn = r_warn;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_door_countdown.sv
// Directed bench for door_countdown: vector table for the main countdown flows plus hand sequences for corner cases.
module tb_door_countdown;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic [6:0] load_sec = 7'd0;
  logic       hold = 1'b0;
  logic       cancel = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] sec_tens, sec_ones;
  logic       running, expired, alarm, warn;

`ifdef WARN_BLINK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  door_countdown dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .start(start),
    .load_sec(load_sec), .hold(hold), .cancel(cancel), .ack(ack),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running),
    .expired(expired), .alarm(alarm), .warn(warn)
  );

  always #5 clk_in = ~clk_in;

  typedef enum {OP_START, OP_TICK, OP_ACK, OP_CANCEL, OP_HOLD_ON, OP_HOLD_OFF} op_e;
  typedef struct {
    op_e op;
    int  arg;
    int  t;
    int  o;
    int  run;
    int  alm;
    int  wrn;
    int  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   g_exp = 0;

  function automatic void add(op_e op, int arg, int t, int o, int run, int alm, int wrn, int exp);
    vec_t v;
    v.op = op; v.arg = arg; v.t = t; v.o = o;
    v.run = run; v.alm = alm; v.wrn = wrn; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input int t, input int o, input int run, input int alm, input int wrn);
    chk({nm, " tens"}, int'(sec_tens), t);
    chk({nm, " ones"}, int'(sec_ones), o);
    chk({nm, " running"}, int'(running), run);
    chk({nm, " alarm"}, int'(alarm), alm);
    chk({nm, " warn"}, int'(warn), wrn * WB);
  endtask

  task automatic step();
    @(negedge clk_in);
    if (expired) g_exp++;
  endtask

  // Tick held high long enough to cross the synchroniser, then low long enough to re-arm it.
  task automatic do_tick();
    tick_in = 1'b1;
    repeat (5) step();
    tick_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic do_op(input op_e op, input int arg);
    g_exp = 0;
    case (op)
      OP_START:    begin load_sec = 7'(arg); start = 1'b1; step(); start = 1'b0; end
      OP_TICK:     do_tick();
      OP_ACK:      begin ack = 1'b1; step(); ack = 1'b0; end
      OP_CANCEL:   begin cancel = 1'b1; step(); cancel = 1'b0; end
      OP_HOLD_ON:  begin hold = 1'b1; step(); end
      OP_HOLD_OFF: begin hold = 1'b0; step(); end
      default:     step();
    endcase
  endtask

  initial begin
    // Normal countdown from 12 with borrow at 10->09; blink at 5..1 when compiled in
    add(OP_START, 12, 1, 2, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 1, 1, 0, 0, 0);
    add(OP_TICK, 0, 1, 0, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 9, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 8, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 7, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 6, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 5, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 4, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 3, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 2, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 1, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 0, 0, 1, 0, 1);
    add(OP_TICK, 0, 0, 0, 0, 1, 0, 0);
    add(OP_ACK, 0, 0, 0, 0, 0, 0, 0);
    // Saturation and zero load
    add(OP_START, 120, 9, 9, 1, 0, 0, 0);
    add(OP_CANCEL, 0, 0, 0, 0, 0, 0, 0);
    add(OP_START, 0, 0, 0, 0, 0, 0, 0);
    // Hold freezes the count; discarded ticks still toggle the blink
    add(OP_START, 5, 0, 5, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 4, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 3, 1, 0, 1, 0);
    add(OP_HOLD_ON, 0, 0, 3, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 3, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 3, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 3, 1, 0, 0, 0);
    add(OP_HOLD_OFF, 0, 0, 3, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 2, 1, 0, 1, 0);
    add(OP_TICK, 0, 0, 1, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 0, 0, 1, 0, 1);
    // Restart straight out of ALARM
    add(OP_START, 3, 0, 3, 1, 0, 1, 0);
    add(OP_CANCEL, 0, 0, 0, 0, 0, 0, 0);
    // Load 7: no blink at 7 and 6, first blink at 5
    add(OP_START, 7, 0, 7, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 6, 1, 0, 0, 0);
    add(OP_TICK, 0, 0, 5, 1, 0, 1, 0);
    add(OP_ACK, 0, 0, 5, 1, 0, 1, 0);
    add(OP_CANCEL, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk_in);
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset expired", int'(expired), 0);
    rst = 1'b1;
    @(negedge clk_in);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].arg);
      chk_out($sformatf("row%0d", i), vecs[i].t, vecs[i].o, vecs[i].run, vecs[i].alm, vecs[i].wrn);
      chk($sformatf("row%0d expired_cycles", i), g_exp, vecs[i].exp);
    end

    // Asynchronous reset in the middle of a count
    do_op(OP_START, 30);
    repeat (3) do_tick();
    chk_out("midcount", 2, 7, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst expired", int'(expired), 0);
    @(negedge clk_in);
    rst = 1'b1;
    do_tick();
    chk_out("after_rst tick", 0, 0, 0, 0, 0);

    // cancel and start together: cancel wins, in RUN and in IDLE
    do_op(OP_START, 20);
    load_sec = 7'd30; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk_out("cancel+start run", 0, 0, 0, 0, 0);
    load_sec = 7'd30; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk_out("cancel+start idle", 0, 0, 0, 0, 0);

    // start coincides with tick_rise: reload wins, tick is lost; long-high tick decrements once
    do_op(OP_START, 20);
    tick_in = 1'b1;
    step(); step();
    load_sec = 7'd15; start = 1'b1;
    step();
    start = 1'b0;
    chk_out("start+tick", 1, 5, 1, 0, 0);
    repeat (20) step();
    tick_in = 1'b0;
    repeat (4) step();
    chk_out("start+tick held", 1, 5, 1, 0, 0);
    tick_in = 1'b1;
    repeat (40) step();
    tick_in = 1'b0;
    repeat (4) step();
    chk_out("long tick", 1, 4, 1, 0, 0);
    do_op(OP_CANCEL, 0);
    chk_out("final cancel", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
